coin_input_conditioner: RTL and testbench

Upstream front-end for the coin counter. Takes the two raw, bouncing, asynchronous coin push-buttons, then synchronises and debounces each one. For each accepted press it emits exactly one single-cycle pulse on coin_100 or coin_500, and the counter consumes these pulses directly. It guarantees the two pulses are never asserted in the same cycle, so the counter never has to resolve simultaneous coins.

---
 rtl/coin_input_conditioner.sv | 203 ++++++++++++++++++++
 tb/tb_coin_input_conditioner.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/coin_input_conditioner.sv
// -----------------------------------------------------------------------------
// coin_input_conditioner
//
// Front-end for the coin counter. Each raw, bouncing, asynchronous coin button
// goes through a polarity fix, a 2-flop synchroniser and a debounce FSM. Every
// accepted press produces exactly one single-cycle pulse on coin_100 or
// coin_500. The two pulses are never high in the same cycle. When both
// channels accept together, 100 goes first and 500 follows one cycle later.
//
// Parameters:
//   DEBOUNCE_CYCLES : consecutive stable samples needed to accept a press or a
//                     release (legal 2 .. 2^20-1)
//   ACTIVE_LOW      : 1 = raw button reads 0 when pressed, 0 = reads 1
//
// Ports:
//   clk            in   system clock; all state changes on the rising edge
//   reset          in   asynchronous, active-high; clears all state
//   btn_100_raw    in   raw 100-coin button, asynchronous to clk
//   btn_500_raw    in   raw 500-coin button, asynchronous to clk
//   coin_100       out  one-cycle pulse per accepted 100 press (registered)
//   coin_500       out  one-cycle pulse per accepted 500 press (registered)
//   btn_100_level  out  debounced level, 1 = pressed (registered)
//   btn_500_level  out  debounced level, 1 = pressed (registered)
//
// Handshake: coin_100 and coin_500 are fire-and-forget strobes with no ready
// signal. The consumer must take each strobe in the cycle it is high, and at
// most one of the two strobes is high in any cycle.
//
// Channel index 0 is the 100 channel and index 1 is the 500 channel. The
// per-channel FSM state lives in state_q[ch] so that checkers can bind to it.
// -----------------------------------------------------------------------------
module coin_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_100_raw,
  input  logic btn_500_raw,
  output logic coin_100,
  output logic coin_500,
  output logic btn_100_level,
  output logic btn_500_level
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_LOCKOUT      = 3'd0,
    ST_IDLE         = 3'd1,
    ST_PRESS_WAIT   = 3'd2,
    ST_PRESSED      = 3'd3,
    ST_RELEASE_WAIT = 3'd4
  } state_e;

  // Logical "pressed" = 1 regardless of board polarity.
  logic [1:0] pressed_raw;
  assign pressed_raw = {btn_500_raw, btn_100_raw} ^ {2{ACTIVE_LOW}};

  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  state_e           state_q [2];
  state_e           state_d [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];
  logic [1:0]       level_q, level_d;
  logic [1:0]       accept;

  logic pend_100_q, pend_100_d;
  logic pend_500_q, pend_500_d;
  logic coin_100_q, coin_100_d;
  logic coin_500_q, coin_500_d;
  logic issue_100, issue_500;

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  always_comb begin
    sync1_d = pressed_raw;
    sync2_d = sync1_q;
  end

  // ---------------------------------------------------------------------------
  // Per-channel debounce FSM. accept[ch] is high for the single cycle in which
  // PRESS_WAIT has seen its last required sample and moves to PRESSED.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      state_d[ch] = state_q[ch];
      cnt_d[ch]   = cnt_q[ch];
      accept[ch]  = 1'b0;
      case (state_q[ch])
        // A button held through reset must be released for N samples before
        // it can count, so it never yields a phantom coin.
        ST_LOCKOUT: begin
          if (sync2_q[ch]) begin
            cnt_d[ch] = '0;
          end else if (cnt_q[ch] == CNT_LAST) begin
            state_d[ch] = ST_IDLE;
            cnt_d[ch]   = '0;
          end else begin
            cnt_d[ch] = cnt_q[ch] + 1'b1;
          end
        end
        ST_IDLE: begin
          if (sync2_q[ch]) begin
            state_d[ch] = ST_PRESS_WAIT;
            cnt_d[ch]   = CNT_W'(1);
          end
        end
        ST_PRESS_WAIT: begin
          if (!sync2_q[ch]) begin
            state_d[ch] = ST_IDLE;
            cnt_d[ch]   = '0;
          end else if (cnt_q[ch] == CNT_LAST) begin
            state_d[ch] = ST_PRESSED;
            cnt_d[ch]   = '0;
            accept[ch]  = 1'b1;
          end else begin
            cnt_d[ch] = cnt_q[ch] + 1'b1;
          end
        end
        ST_PRESSED: begin
          if (!sync2_q[ch]) begin
            state_d[ch] = ST_RELEASE_WAIT;
            cnt_d[ch]   = CNT_W'(1);
          end
        end
        // A bounce back to pressed returns to PRESSED without a new pulse.
        ST_RELEASE_WAIT: begin
          if (sync2_q[ch]) begin
            state_d[ch] = ST_PRESSED;
            cnt_d[ch]   = '0;
          end else if (cnt_q[ch] == CNT_LAST) begin
            state_d[ch] = ST_IDLE;
            cnt_d[ch]   = '0;
          end else begin
            cnt_d[ch] = cnt_q[ch] + 1'b1;
          end
        end
        default: begin
          state_d[ch] = ST_LOCKOUT;
          cnt_d[ch]   = '0;
        end
      endcase
      level_d[ch] = (state_d[ch] == ST_PRESSED) ||
                    (state_d[ch] == ST_RELEASE_WAIT);
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration. A pending 500 beats a new 100 accept, and any 100 (accept or
  // pending) beats a new 500 accept. The loser is parked in its pending flag
  // for one cycle. One slot per channel is enough because N >= 2 keeps two
  // accepts on the same channel far apart.
  // ---------------------------------------------------------------------------
  always_comb begin
    issue_100  = (accept[0] || pend_100_q) && !pend_500_q;
    issue_500  = pend_500_q || (accept[1] && !accept[0] && !pend_100_q);
    coin_100_d = issue_100;
    coin_500_d = issue_500;
    pend_100_d = (accept[0] || pend_100_q) && !issue_100;
    pend_500_d = (accept[1] || pend_500_q) && !issue_500;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 2'b00;
      sync2_q    <= 2'b00;
      state_q[0] <= ST_LOCKOUT;
      state_q[1] <= ST_LOCKOUT;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
      level_q    <= 2'b00;
      pend_100_q <= 1'b0;
      pend_500_q <= 1'b0;
      coin_100_q <= 1'b0;
      coin_500_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
      level_q    <= level_d;
      pend_100_q <= pend_100_d;
      pend_500_q <= pend_500_d;
      coin_100_q <= coin_100_d;
      coin_500_q <= coin_500_d;
    end
  end

  assign coin_100      = coin_100_q;
  assign coin_500      = coin_500_q;
  assign btn_100_level = level_q[0];
  assign btn_500_level = level_q[1];

endmodule

// File: tb/tb_coin_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_coin_input_conditioner
//
// Directed bench for coin_input_conditioner with DEBOUNCE_CYCLES = 4 and
// ACTIVE_LOW = 1. Inputs are driven 1 time unit after a rising edge. With
// that timing, "edge 0" is the first rising edge after a drive. A pulse that
// is expected "after edge 5" is sampled 1 unit after the sixth rising edge.
// A negedge monitor logs every output pulse into obs_q. Each scenario pushes
// its expected pulse sequence into exp_q, and the two queues are compared.
// -----------------------------------------------------------------------------
module tb_coin_input_conditioner;

  localparam int N = 4;

  localparam logic [1:0] EV_100 = 2'b01;
  localparam logic [1:0] EV_500 = 2'b10;

  logic clk = 1'b0;
  logic reset;
  logic btn_100_raw;
  logic btn_500_raw;
  logic coin_100;
  logic coin_500;
  logic btn_100_level;
  logic btn_500_level;

  int total = 0;
  int bad   = 0;

  logic [1:0] exp_q[$];
  logic [1:0] obs_q[$];

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  coin_input_conditioner #(
    .DEBOUNCE_CYCLES(N),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_100_raw  (btn_100_raw),
    .btn_500_raw  (btn_500_raw),
    .coin_100     (coin_100),
    .coin_500     (coin_500),
    .btn_100_level(btn_100_level),
    .btn_500_level(btn_500_level)
  );

  // Pulse monitor: {coin_500, coin_100}, so a same-cycle pair logs as 2'b11.
  always @(negedge clk) begin
    if (coin_100 || coin_500) obs_q.push_back({coin_500, coin_100});
  end

  // ---------------------------------------------------------------------------
  // Driver and check tasks
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic c1, input logic c5,
                            input logic l1, input logic l5);
    check({tag, "_coin_100"}, coin_100, c1);
    check({tag, "_coin_500"}, coin_500, c5);
    check({tag, "_level_100"}, btn_100_level, l1);
    check({tag, "_level_500"}, btn_500_level, l5);
  endtask

  task automatic check_events(input string tag);
    int n;
    check({tag, "_event_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_event%0d", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset       = 1'b1;
    btn_100_raw = 1'b1;
    btn_500_raw = 1'b1;
    step(3);
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step(10);  // leave LOCKOUT (N released samples)
    check_outs("post_lockout", 1'b0, 1'b0, 1'b0, 1'b0);
    obs_q.delete();

    // T1: single clean 100 press, pulse exactly after edge 5
    btn_100_raw = 1'b0;
    step(5);
    check_outs("t1_edge4", 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    check_outs("t1_edge5", 1'b1, 1'b0, 1'b1, 1'b0);
    step(1);
    check_outs("t1_edge6", 1'b0, 1'b0, 1'b1, 1'b0);
    step(10);
    exp_q.push_back(EV_100);
    check_events("t1");
    btn_100_raw = 1'b1;
    step(10);
    check_outs("t1_released", 1'b0, 1'b0, 1'b0, 1'b0);

    // T2: 500 button chatters every cycle, which must be rejected
    for (int i = 0; i < 20; i++) begin
      btn_500_raw = (i % 2 == 1);
      step(1);
      check($sformatf("t2_level_500_%0d", i), btn_500_level, 1'b0);
    end
    btn_500_raw = 1'b1;
    step(10);
    check_outs("t2_end", 1'b0, 1'b0, 1'b0, 1'b0);
    check_events("t2");

    // T3: both pressed on the same edge, so 100 goes out first and 500 next
    btn_100_raw = 1'b0;
    btn_500_raw = 1'b0;
    step(5);
    check_outs("t3_edge4", 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    check_outs("t3_edge5", 1'b1, 1'b0, 1'b1, 1'b1);
    step(1);
    check_outs("t3_edge6", 1'b0, 1'b1, 1'b1, 1'b1);
    step(1);
    check_outs("t3_edge7", 1'b0, 1'b0, 1'b1, 1'b1);
    step(10);
    exp_q.push_back(EV_100);
    exp_q.push_back(EV_500);
    check_events("t3");
    btn_100_raw = 1'b1;
    btn_500_raw = 1'b1;
    step(10);
    check_outs("t3_released", 1'b0, 1'b0, 1'b0, 1'b0);

    // T4: press, bouncy release, then a clean second press gives 2 pulses
    btn_100_raw = 1'b0;
    step(10);
    btn_100_raw = 1'b1;
    step(2);
    btn_100_raw = 1'b0;
    step(2);
    btn_100_raw = 1'b1;
    step(2);
    btn_100_raw = 1'b0;
    step(2);
    check_outs("t4_bounce", 1'b0, 1'b0, 1'b1, 1'b0);
    btn_100_raw = 1'b1;
    step(10);
    check_outs("t4_released", 1'b0, 1'b0, 1'b0, 1'b0);
    btn_100_raw = 1'b0;
    step(10);
    btn_100_raw = 1'b1;
    step(10);
    exp_q.push_back(EV_100);
    exp_q.push_back(EV_100);
    check_events("t4");

    // T5: reset mid-PRESS_WAIT with the button still held
    btn_100_raw = 1'b0;
    step(3);
    reset = 1'b1;
    #1;
    check_outs("t5_reset_now", 1'b0, 1'b0, 1'b0, 1'b0);
    step(3);
    check_outs("t5_in_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step(20);
    check_outs("t5_held", 1'b0, 1'b0, 1'b0, 1'b0);
    check_events("t5_held");
    btn_100_raw = 1'b1;
    step(10);
    btn_100_raw = 1'b0;
    step(5);
    check_outs("t5_edge4", 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    check_outs("t5_edge5", 1'b1, 1'b0, 1'b1, 1'b0);
    step(10);
    btn_100_raw = 1'b1;
    step(10);
    exp_q.push_back(EV_100);
    check_events("t5");

    // T6: async reset while 500 is pending, so the pending coin is discarded
    btn_100_raw = 1'b0;
    btn_500_raw = 1'b0;
    step(6);
    check_outs("t6_edge5", 1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    check_outs("t6_reset_now", 1'b0, 1'b0, 1'b0, 1'b0);
    btn_100_raw = 1'b1;
    btn_500_raw = 1'b1;
    step(3);
    check_outs("t6_in_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step(15);
    check_outs("t6_after", 1'b0, 1'b0, 1'b0, 1'b0);
    check_events("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
